// File: rtl/inst_fetch_pkg.sv
// Purpose: shared widths, reset polarity, fetch-state encodings and constants for the fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package inst_fetch_pkg;

    localparam int          AddrLen   = 32;
    localparam int          InstLen   = 32;
    localparam logic        RstActive = 1'b0;
    localparam logic [31:0] NopInst   = 32'h0000_0013;

    // FETCHk encodes the byte index k in bits [1:0]; FULL holds a completed word.
    typedef enum logic [2:0] {
        FETCH0 = 3'd0,
        FETCH1 = 3'd1,
        FETCH2 = 3'd2,
        FETCH3 = 3'd3,
        FULL   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Purpose: instruction fetch; assembles 32-bit words from four little-endian byte reads into a one-entry output slot.
// Latency: 4 cycles per instruction with memory always ready; first valid after the 4th edge following reset release.
// Backpressure: one completed word is parked in the assembly buffer (FULL, no requests) while decode stalls.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   mem_req_o / mem_addr_o   byte read request and address (fetch_pc + byte index)
//   mem_ready_i / mem_data_i returned byte, valid when mem_ready_i is high
//   br_taken_i / br_target_i redirect from execute; highest priority, flushes in-flight work
//   pc_o / inst_o            presented pc and instruction
//   inst_valid_o / id_ready_i valid/ready handshake to decode
//   fetch_cnt_o              transfer counter, present only when IF_PERF_CNT_EN is defined
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = AddrLen,
    parameter int                INST_W   = InstLen,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic [7:0]        mem_data_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    input  logic              id_ready_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o
`endif
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [INST_W-1:0] r_buf;
    logic [INST_W-1:0] w_buf_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_valid;

    logic              w_xfer;
    logic              w_slot_free;
    logic              w_load;
    logic [INST_W-1:0] w_load_inst;
    logic [ADDR_W-1:0] w_br_pc;
    logic [1:0]        w_byte_idx;
    logic [ADDR_W-1:0] w_byte_addr;

    assign w_xfer      = r_valid & id_ready_i;
    // The slot can take a new word if it is empty or is being drained this very cycle.
    assign w_slot_free = ~r_valid | w_xfer;
    assign w_br_pc     = br_target_i & ~ADDR_W'(3);
    assign w_byte_idx  = r_state[1:0];
    assign w_byte_addr = r_fetch_pc + ADDR_W'(w_byte_idx);

    // Request is held off while reset is asserted so the port is quiet until the first post-reset cycle.
    assign mem_req_o  = (rst != RstActive) && (r_state != FULL);
    assign mem_addr_o = mem_req_o ? w_byte_addr : '0;

    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_buf_nxt      = r_buf;
        w_load         = 1'b0;
        w_load_inst    = r_buf;
        case (r_state)
            FETCH0: begin
                if (mem_ready_i) begin
                    w_buf_nxt[7:0] = mem_data_i;
                    w_state_nxt    = FETCH1;
                end
            end
            FETCH1: begin
                if (mem_ready_i) begin
                    w_buf_nxt[15:8] = mem_data_i;
                    w_state_nxt     = FETCH2;
                end
            end
            FETCH2: begin
                if (mem_ready_i) begin
                    w_buf_nxt[23:16] = mem_data_i;
                    w_state_nxt      = FETCH3;
                end
            end
            FETCH3: begin
                if (mem_ready_i) begin
                    w_load_inst = {mem_data_i, r_buf[23:0]};
                    if (w_slot_free) begin
                        w_load         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
                        w_state_nxt    = FETCH0;
                    end else begin
                        w_buf_nxt   = w_load_inst;
                        w_state_nxt = FULL;
                    end
                end
            end
            FULL: begin
                if (w_xfer) begin
                    w_load         = 1'b1;
                    w_load_inst    = r_buf;
                    w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(4);
                    w_state_nxt    = FETCH0;
                end
            end
            default: begin
                w_state_nxt = FETCH0;
            end
        endcase
        // Redirect wins: drops any byte returned now and any parked word.
        if (br_taken_i) begin
            w_state_nxt    = FETCH0;
            w_fetch_pc_nxt = w_br_pc;
            w_load         = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FETCH0;
            r_fetch_pc <= RESET_PC;
            r_buf      <= '0;
            r_pc       <= '0;
            r_inst     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_buf      <= w_buf_nxt;
            if (w_load) begin
                r_pc   <= r_fetch_pc;
                r_inst <= w_load_inst;
            end
            r_valid <= ~br_taken_i & (w_load | (r_valid & ~w_xfer));
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;

    // Counts every accepted transfer, including one that coincides with a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_cnt <= '0;
        end else if (w_xfer) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
`endif

endmodule
